// File: rtl/systolic_writeback_pkg.sv
// Shared definitions for the systolic array writeback stage.
//   wb_state_e : writeback sequencing FSM states
//   sat_max/min: signed saturation bounds for a given stored width
//   lane_lsb   : bit offset of a lane inside a packed row
package systolic_writeback_pkg;

   typedef enum logic [1:0] {
      WB_IDLE   = 2'd0,
      WB_ACTIVE = 2'd1,
      WB_DRAIN  = 2'd2
   } wb_state_e;

   function automatic int sat_max(input int out_width);
      return (1 << (out_width - 1)) - 1;
   endfunction

   function automatic int sat_min(input int out_width);
      return -(1 << (out_width - 1));
   endfunction

   function automatic int lane_lsb(input int lane, input int width);
      return lane * width;
   endfunction

endpackage

// File: rtl/wb_row_fifo.sv
// Synchronous row buffer for the writeback stage.
// Ports:
//   clk, srst      : clock, synchronous active-high reset (pointers only)
//   push, wdata    : write request and entry
//   pop            : consume the head entry
//   rdata          : head entry (valid while !empty)
//   full, empty    : occupancy flags
// A push while full is accepted when a pop happens in the same cycle.
module wb_row_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             srst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W:0]   wr_ptr;
   logic [PTR_W:0]   rd_ptr;
   logic             do_push;
   logic             do_pop;

   // Extra pointer MSB distinguishes full from empty when the indices match.
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                    (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk) begin
      if (srst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[PTR_W-1:0]] <= wdata;
   end

   assign rdata = mem[rd_ptr[PTR_W-1:0]];

endmodule

// File: rtl/systolic_writeback.sv
// Result writeback stage of the systolic array controller.
// Captures accumulator rows on sram_write_enable, requantizes each lane
// (arithmetic shift + signed saturation), tags the row with its SRAM
// address, buffers it and writes it out under a ready handshake.
// Ports:
//   clk, srst          : clock, synchronous active-high reset
//   tpu_start          : job start, clears overflow
//   sram_write_enable  : row capture strobe
//   matrix_index       : row index within data set
//   data_set           : data set index
//   row_data           : ARRAY_SIZE signed accumulator lanes
//   tpu_done           : controller done pulse
//   sram_ready         : SRAM accepts a write this cycle
//   sram_wen/addr/wdata: SRAM write port
//   wb_done            : one-cycle pulse after drain completes
//   overflow           : sticky, a row was dropped
//
// state     | meaning
// ----------+------------------------------------------------
// WB_IDLE   | no job in flight
// WB_ACTIVE | rows being captured, controller still running
// WB_DRAIN  | controller done, flushing S1 and the FIFO
module systolic_writeback
   import systolic_writeback_pkg::*;
#(
   parameter int ARRAY_SIZE   = 8,
   parameter int ACC_WIDTH    = 20,
   parameter int OUT_WIDTH    = 8,
   parameter int QUANT_SHIFT  = 4,
   parameter int FIFO_DEPTH   = 4,
   parameter int ADDR_WIDTH   = 10,
   parameter int ROWS_PER_SET = 16
) (
   input  logic                            clk,
   input  logic                            srst,
   input  logic                            tpu_start,
   input  logic                            sram_write_enable,
   input  logic [5:0]                      matrix_index,
   input  logic [5:0]                      data_set,
   input  logic [ARRAY_SIZE*ACC_WIDTH-1:0] row_data,
   input  logic                            tpu_done,
   input  logic                            sram_ready,
   output logic                            sram_wen,
   output logic [ADDR_WIDTH-1:0]           sram_addr,
   output logic [ARRAY_SIZE*OUT_WIDTH-1:0] sram_wdata,
   output logic                            wb_done,
   output logic                            overflow
);

   localparam int ROW_W   = ARRAY_SIZE * OUT_WIDTH;
   localparam int ENTRY_W = ADDR_WIDTH + ROW_W;
   localparam logic signed [ACC_WIDTH-1:0] Q_MAX = ACC_WIDTH'(sat_max(OUT_WIDTH));
   localparam logic signed [ACC_WIDTH-1:0] Q_MIN = ACC_WIDTH'(sat_min(OUT_WIDTH));

   logic [ROW_W-1:0]      quant_row;
   logic [ADDR_WIDTH-1:0] capture_addr;
   logic                  s1_valid;
   logic [ENTRY_W-1:0]    s1_entry;
   logic [ENTRY_W-1:0]    head_entry;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic                  fifo_push;
   logic                  fifo_pop;
   logic                  row_drop;
   wb_state_e             state;
   wb_state_e             state_nxt;
   logic                  drain_done;

   for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_lane
      localparam int A_LSB = lane_lsb(i, ACC_WIDTH);
      localparam int O_LSB = lane_lsb(i, OUT_WIDTH);
      logic signed [ACC_WIDTH-1:0] acc;
      logic signed [ACC_WIDTH-1:0] q;
      assign acc = row_data[A_LSB +: ACC_WIDTH];
      assign q   = acc >>> QUANT_SHIFT;
      assign quant_row[O_LSB +: OUT_WIDTH] =
         (q > Q_MAX) ? Q_MAX[OUT_WIDTH-1:0] :
         (q < Q_MIN) ? Q_MIN[OUT_WIDTH-1:0] :
                       q[OUT_WIDTH-1:0];
   end

   // Full-width product/sum, truncation is the modulo on the address space.
   assign capture_addr = ADDR_WIDTH'(32'(data_set) * 32'(ROWS_PER_SET) + 32'(matrix_index));

   always_ff @(posedge clk) begin
      if (srst) s1_valid <= 1'b0;
      else      s1_valid <= sram_write_enable;
   end

   always_ff @(posedge clk) begin
      if (sram_write_enable) s1_entry <= {capture_addr, quant_row};
   end

   assign fifo_pop  = sram_wen && sram_ready;
   assign fifo_push = s1_valid && (!fifo_full || fifo_pop);
   assign row_drop  = s1_valid && fifo_full && !fifo_pop;

   wb_row_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .srst  (srst),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .wdata (s1_entry),
      .rdata (head_entry),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Storage is not reset, so the port is zeroed whenever nothing is pending.
   assign sram_wen   = !fifo_empty;
   assign sram_addr  = sram_wen ? head_entry[ENTRY_W-1 -: ADDR_WIDTH] : '0;
   assign sram_wdata = sram_wen ? head_entry[ROW_W-1:0] : '0;

   always_comb begin
      state_nxt  = state;
      drain_done = 1'b0;
      unique case (state)
         WB_IDLE: begin
            if (tpu_done)               state_nxt = WB_DRAIN;
            else if (sram_write_enable) state_nxt = WB_ACTIVE;
         end
         WB_ACTIVE: begin
            if (tpu_done) state_nxt = WB_DRAIN;
         end
         WB_DRAIN: begin
            if (!s1_valid && fifo_empty && !sram_write_enable) begin
               state_nxt  = WB_IDLE;
               drain_done = 1'b1;
            end
         end
         default: state_nxt = WB_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         state    <= WB_IDLE;
         wb_done  <= 1'b0;
         overflow <= 1'b0;
      end else begin
         state   <= state_nxt;
         wb_done <= drain_done;
         if (row_drop)       overflow <= 1'b1;
         else if (tpu_start) overflow <= 1'b0;
      end
   end

endmodule
